split_arrays: RTL and testbench

SPLIT_ARRAYS -- requirements
Module: split_arrays

---
 rtl/sort_pkg.sv | 13 +
 rtl/split_arrays.sv | 94 +++++++++
 tb/tb_split_arrays.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the array split/sort datapath: FSM state encoding and element width.
package sort_pkg;

  localparam int ELEM_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_L = 2'd1,
    FILL_R = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/split_arrays.sv
// Drains 2*INPUT_ARR_LEN elements from a source FIFO, sending the first half to the
// left FIFO and the second half to the right FIFO, then pulses done for one cycle.
module split_arrays
  import sort_pkg::*;
#(
  parameter int INPUT_ARR_LEN = 2,
  parameter int VAR_LEN       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_empty,
  output logic              rd_in,
  output logic [ELEM_W-1:0] data_L,
  output logic              wr_L,
  input  logic              full_L,
  output logic [ELEM_W-1:0] data_R,
  output logic              wr_R,
  input  logic              full_R,
  output logic              busy,
  output logic              done
);

  localparam logic [VAR_LEN-1:0] LAST_IDX = VAR_LEN'(INPUT_ARR_LEN - 1);

  state_t             state_q, state_d;
  logic [VAR_LEN-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Strobes are gated by rst so an abandoned job never pops or writes in the reset cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_in   = 1'b0;
    wr_L    = 1'b0;
    wr_R    = 1'b0;
    data_L  = '0;
    data_R  = '0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (start) state_d = FILL_L;
      end
      FILL_L: begin
        busy = 1'b1;
        if (!rst && !in_empty && !full_L) begin
          rd_in  = 1'b1;
          wr_L   = 1'b1;
          data_L = in_data;
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = FILL_R;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      FILL_R: begin
        busy = 1'b1;
        if (!rst && !in_empty && !full_R) begin
          rd_in  = 1'b1;
          wr_R   = 1'b1;
          data_R = in_data;
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_split_arrays.sv
// Self-checking bench for split_arrays: job-level reference model checked every cycle,
// plus literal expectations for element order, pop counts and done timing per scenario.
module tb_split_arrays;

  localparam int LEN = 2;

  logic       clk = 1'b0;
  logic       rst, start, in_empty, full_L, full_R;
  logic [7:0] in_data;
  logic       rd_in, wr_L, wr_R, busy, done;
  logic [7:0] data_L, data_R;

  split_arrays #(.INPUT_ARR_LEN(LEN), .VAR_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_empty(in_empty), .rd_in(rd_in),
    .data_L(data_L), .wr_L(wr_L), .full_L(full_L),
    .data_R(data_R), .wr_R(wr_R), .full_R(full_R),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] src_q[$];
  logic [7:0] l_log[$];
  logic [7:0] r_log[$];
  bit         force_empty = 1'b0;
  bit         pop_req     = 1'b0;
  bit         checking    = 1'b0;
  int         cur_i = 0, pop_cnt = 0, done_cnt = 0, done_at = -1;
  int         n_checks = 0, n_pass = 0;
  int         m_phase = 0;  // 0 idle, 1 transferring, 2 done pulse
  int         m_k = 0;      // elements moved so far in the current job

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cur_i);
  endtask

  function automatic int unsigned pack(input logic [7:0] q[$]);
    int unsigned v = 0;
    foreach (q[i]) v |= int'(q[i]) << (8 * i);
    return v;
  endfunction

  function automatic void refresh();
    in_empty = force_empty || (src_q.size() == 0);
    in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endfunction

  task automatic tick();
    refresh();
    @(posedge clk);
    #1;
    if (pop_req) begin
      void'(src_q.pop_front());
      pop_req = 1'b0;
    end
  endtask

  // Reference model: the first LEN moved elements go left, the next LEN go right.
  always @(negedge clk) begin
    logic to_r, xfer;
    to_r = (m_k >= LEN);
    xfer = (m_phase == 1) && !rst && !in_empty && !(to_r ? full_R : full_L);
    if (checking) begin
      check("rd_in",  rd_in,  xfer);
      check("wr_L",   wr_L,   xfer && !to_r);
      check("wr_R",   wr_R,   xfer && to_r);
      check("data_L", data_L, (xfer && !to_r) ? in_data : 8'h00);
      check("data_R", data_R, (xfer && to_r) ? in_data : 8'h00);
      check("busy",   busy,   m_phase != 0);
      check("done",   done,   m_phase == 2);
    end
    if (wr_L) l_log.push_back(data_L);
    if (wr_R) r_log.push_back(data_R);
    if (rd_in) begin
      pop_cnt++;
      pop_req = 1'b1;
    end
    if (done) begin
      done_cnt++;
      done_at = cur_i;
    end
    if (rst) begin
      m_phase = 0;
      m_k     = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_k     = 0;
      end
    end else if (m_phase == 1) begin
      if (xfer) m_k++;
      if (m_k == 2 * LEN) m_phase = 2;
    end else begin
      m_phase = 0;
    end
  end

  // Scenarios: 0 plain, 1 source empty c2-c3, 2 full_R c3-c6, 3 start at c2,
  // 4 rst at c3, 5 back-to-back restart at c6, 6 full_L c1-c2, 7 rst+start at c0.
  task automatic apply_stimulus(input int scen, input int ncyc);
    l_log.delete();
    r_log.delete();
    pop_cnt  = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < ncyc; i++) begin
      cur_i       = i;
      start       = (i == 0) || (scen == 3 && i == 2) || (scen == 5 && i == 6);
      force_empty = (scen == 1) && (i == 2 || i == 3);
      full_L      = (scen == 6) && (i == 1 || i == 2);
      full_R      = (scen == 2) && (i >= 3 && i <= 6);
      rst         = ((scen == 4) && (i == 3)) || ((scen == 7) && (i == 0));
      tick();
    end
    start       = 1'b0;
    force_empty = 1'b0;
    full_L      = 1'b0;
    full_R      = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic check_output(input string tag, input int exp_pops, input int exp_dones,
                              input int exp_done_at, input int unsigned exp_l,
                              input int unsigned exp_r);
    check({tag, "_pops"},    pop_cnt,      exp_pops);
    check({tag, "_dones"},   done_cnt,     exp_dones);
    check({tag, "_done_at"}, done_at,      exp_done_at);
    check({tag, "_L"},       pack(l_log),  exp_l);
    check({tag, "_R"},       pack(r_log),  exp_r);
  endtask

  task automatic load(input logic [7:0] a, b, c, d);
    src_q.delete();
    src_q.push_back(a); src_q.push_back(b); src_q.push_back(c); src_q.push_back(d);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; full_L = 1'b0; full_R = 1'b0;
    tick();
    checking = 1'b1;
    start = 1'b1;
    tick();
    check("reset_busy", busy, 0);
    check("reset_rd_in", rd_in, 0);
    rst = 1'b0; start = 1'b0;
    tick();

    load(5, 3, 8, 1);  apply_stimulus(0, 10);
    check_output("plain", 4, 1, 5, 32'h0305, 32'h0108);

    load(5, 3, 8, 1);  apply_stimulus(1, 12);
    check_output("empty_stall", 4, 1, 7, 32'h0305, 32'h0108);

    load(5, 3, 8, 1);  apply_stimulus(2, 14);
    check_output("fullR_stall", 4, 1, 9, 32'h0305, 32'h0108);

    load(5, 3, 8, 1);  apply_stimulus(3, 10);
    check_output("start_busy", 4, 1, 5, 32'h0305, 32'h0108);

    load(5, 3, 8, 1);  apply_stimulus(4, 10);
    check_output("rst_mid", 2, 0, -1, 32'h0305, 32'h0);
    check("rst_mid_busy", busy, 0);

    load(9, 9, 2, 7);  apply_stimulus(0, 10);
    check_output("after_rst", 4, 1, 5, 32'h0909, 32'h0702);

    load(5, 3, 8, 1);
    src_q.push_back(4); src_q.push_back(6); src_q.push_back(2); src_q.push_back(9);
    apply_stimulus(5, 16);
    check_output("b2b", 8, 2, 11, 32'h06040305, 32'h09020108);

    load(5, 3, 8, 1);  apply_stimulus(6, 12);
    check_output("fullL_stall", 4, 1, 7, 32'h0305, 32'h0108);

    load(5, 3, 8, 1);  apply_stimulus(7, 8);
    check_output("rst_start", 0, 0, -1, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
